// File: rtl/multdiv_seq_ctrl_pkg.sv
// Shared definitions for the mult/div sequencing controller: FSM encoding,
// instruction field constants and the mul/div decode helper.
package mdctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } md_state_t;

    localparam logic [4:0] OP_ALU      = 5'b00000;
    localparam logic [4:0] ALU_MUL     = 5'b00110;
    localparam logic [4:0] ALU_DIV     = 5'b00111;
    localparam logic [4:0] REG_RSTATUS = 5'd30;

    function automatic logic is_md_op(input logic       valid,
                                      input logic [4:0] opcode,
                                      input logic [4:0] aluop);
        return valid && (opcode == OP_ALU) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
    endfunction

endpackage

// File: rtl/multdiv_seq_ctrl_if.sv
// Pipeline / mult-div unit signal bundle seen by the sequencing controller.
interface multdiv_seq_ctrl_if;
    import mdctl_pkg::*;

    logic        x_valid;
    logic [4:0]  x_opcode;
    logic [4:0]  x_aluop;
    logic [4:0]  x_rd;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        md_start_mult;
    logic        md_start_div;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output x_valid, x_opcode, x_aluop, x_rd, md_ready, md_exception, md_result,
        input  md_start_mult, md_start_div, stall, busy, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  x_valid, x_opcode, x_aluop, x_rd, md_ready, md_exception, md_result,
        output md_start_mult, md_start_div, stall, busy, wb_valid, wb_rd, wb_data
    );

endinterface

// File: rtl/multdiv_seq_ctrl_wait_counter.sv
// Wait-cycle counter for the mult/div controller; flags the last permitted
// WAIT cycle so the controller can abort with a timeout.
module md_wait_counter #(
    parameter int WAIT_MAX = 40
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);
    import mdctl_pkg::*;

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] TERM = CW'(WAIT_MAX - 1);

    logic [CW-1:0] r_count;

    // Count register: clear has priority over enable.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_terminal = (r_count == TERM);

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequences the shared multi-cycle mult/div unit: one start pulse per mul/div
// in X, pipeline stall while waiting, then a single writeback record.
module multdiv_seq_ctrl
    import mdctl_pkg::*;
#(
    parameter int          WAIT_MAX = 40,
    parameter logic [31:0] CODE_MUL = 32'd4,
    parameter logic [31:0] CODE_DIV = 32'd5,
    parameter logic [31:0] CODE_TMO = 32'd7
) (
    input logic               i_clock,
    input logic               i_reset,
    multdiv_seq_ctrl_if.slave bus
);

    md_state_t   r_state;
    md_state_t   w_state_next;
    logic        r_is_div;
    logic [4:0]  r_rd;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        w_is_md;
    logic        w_stall;
    logic        w_cnt_clear;
    logic        w_cnt_en;
    logic        w_cnt_term;

    assign w_is_md = is_md_op(bus.x_valid, bus.x_opcode, bus.x_aluop);

    md_wait_counter #(.WAIT_MAX(WAIT_MAX)) u_wait_cnt (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (w_cnt_clear),
        .i_enable   (w_cnt_en),
        .o_terminal (w_cnt_term)
    );

    // FSM state register.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, stall and counter control; md_ready only matters in WAIT.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_cnt_clear  = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_is_md;
                if (w_is_md) begin
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                w_stall      = 1'b1;
                w_cnt_clear  = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (bus.md_ready) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_en = 1'b1;
                    if (w_cnt_term) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operation context and the writeback record; exceptions and timeouts go to rstatus.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_rd      <= 5'd0;
            r_is_div  <= 1'b0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
        end else begin
            if ((r_state == ST_IDLE) && w_is_md) begin
                r_rd     <= bus.x_rd;
                r_is_div <= bus.x_aluop[0];
            end
            if (r_state == ST_WAIT) begin
                if (bus.md_ready) begin
                    if (bus.md_exception) begin
                        r_wb_rd   <= REG_RSTATUS;
                        r_wb_data <= r_is_div ? CODE_DIV : CODE_MUL;
                    end else begin
                        r_wb_rd   <= r_rd;
                        r_wb_data <= bus.md_result;
                    end
                end else if (w_cnt_term) begin
                    r_wb_rd   <= REG_RSTATUS;
                    r_wb_data <= CODE_TMO;
                end
            end
        end
    end

    assign bus.stall         = w_stall;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.md_start_mult = (r_state == ST_START) && !r_is_div;
    assign bus.md_start_div  = (r_state == ST_START) && r_is_div;
    assign bus.wb_valid      = (r_state == ST_DONE);
    assign bus.wb_rd         = (r_state == ST_DONE) ? r_wb_rd : 5'd0;
    assign bus.wb_data       = (r_state == ST_DONE) ? r_wb_data : 32'd0;

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Directed self-checking bench for multdiv_seq_ctrl (WAIT_MAX=40, codes 4/5/7).
module tb_multdiv_seq_ctrl;

    logic clock = 1'b0;
    logic reset;

    multdiv_seq_ctrl_if bus();

    multdiv_seq_ctrl #(
        .WAIT_MAX (40),
        .CODE_MUL (32'd4),
        .CODE_DIV (32'd5),
        .CODE_TMO (32'd7)
    ) dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] s_stall, s_smul, s_sdiv, s_busy, s_wb, s_rd, s_data;
    logic [31:0] n_stall, n_smul, n_sdiv, n_wb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        n_stall = 32'd0;
        n_smul  = 32'd0;
        n_sdiv  = 32'd0;
        n_wb    = 32'd0;
    endtask

    // One clock cycle: sample on the falling edge, then return just after the rising edge.
    task automatic cyc();
        @(negedge clock);
        s_stall = {31'd0, bus.stall};
        s_smul  = {31'd0, bus.md_start_mult};
        s_sdiv  = {31'd0, bus.md_start_div};
        s_busy  = {31'd0, bus.busy};
        s_wb    = {31'd0, bus.wb_valid};
        s_rd    = {27'd0, bus.wb_rd};
        s_data  = bus.wb_data;
        n_stall = n_stall + s_stall;
        n_smul  = n_smul + s_smul;
        n_sdiv  = n_sdiv + s_sdiv;
        n_wb    = n_wb + s_wb;
        @(posedge clock);
        #1;
    endtask

    task automatic set_x(input logic v, input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd);
        bus.x_valid  = v;
        bus.x_opcode = op;
        bus.x_aluop  = alu;
        bus.x_rd     = rd;
    endtask

    task automatic set_md(input logic rdy, input logic exc, input logic [31:0] res);
        bus.md_ready     = rdy;
        bus.md_exception = exc;
        bus.md_result    = res;
    endtask

    initial begin
        reset = 1'b0;
        set_x(1'b0, 5'd0, 5'd0, 5'd0);
        set_md(1'b0, 1'b0, 32'd0);
        clr_counts();

        // Reset state
        cyc();
        cyc();
        chk("rst_busy", s_busy, 32'd0);
        chk("rst_stall", s_stall, 32'd0);
        chk("rst_wb_valid", s_wb, 32'd0);
        chk("rst_wb_rd", s_rd, 32'd0);
        chk("rst_wb_data", s_data, 32'd0);
        reset = 1'b1;
        cyc();

        // Test 1: mul rd=7, ready 3 cycles after the start pulse
        clr_counts();
        set_x(1'b1, 5'b00000, 5'b00110, 5'd7);
        cyc();
        chk("t1_detect_stall", s_stall, 32'd1);
        chk("t1_detect_busy", s_busy, 32'd0);
        chk("t1_detect_start", s_smul, 32'd0);
        cyc();
        chk("t1_start_mult", s_smul, 32'd1);
        chk("t1_start_busy", s_busy, 32'd1);
        cyc();
        cyc();
        set_md(1'b1, 1'b0, 32'h0000_0030);
        cyc();
        chk("t1_ready_stall", s_stall, 32'd1);
        set_md(1'b0, 1'b0, 32'd0);
        cyc();
        chk("t1_wb_valid", s_wb, 32'd1);
        chk("t1_wb_rd", s_rd, 32'd7);
        chk("t1_wb_data", s_data, 32'h0000_0030);
        chk("t1_done_stall", s_stall, 32'd0);
        set_x(1'b0, 5'd0, 5'd0, 5'd0);
        cyc();
        chk("t1_idle_busy", s_busy, 32'd0);
        chk("t1_stall_cycles", n_stall, 32'd5);
        chk("t1_mult_pulses", n_smul, 32'd1);
        chk("t1_div_pulses", n_sdiv, 32'd0);
        chk("t1_wb_count", n_wb, 32'd1);

        // Test 2: div with exception, result dropped
        clr_counts();
        set_x(1'b1, 5'b00000, 5'b00111, 5'd9);
        cyc();
        cyc();
        chk("t2_start_div", s_sdiv, 32'd1);
        set_md(1'b1, 1'b1, 32'hDEAD_BEEF);
        cyc();
        set_md(1'b0, 1'b0, 32'd0);
        cyc();
        chk("t2_wb_valid", s_wb, 32'd1);
        chk("t2_wb_rd", s_rd, 32'd30);
        chk("t2_wb_data", s_data, 32'd5);
        set_x(1'b0, 5'd0, 5'd0, 5'd0);
        cyc();
        chk("t2_div_pulses", n_sdiv, 32'd1);
        chk("t2_mult_pulses", n_smul, 32'd0);
        chk("t2_stall_cycles", n_stall, 32'd3);
        chk("t2_wb_count", n_wb, 32'd1);

        // Test 3: mul with no ready -> timeout after WAIT_MAX wait cycles
        clr_counts();
        set_x(1'b1, 5'b00000, 5'b00110, 5'd12);
        for (int i = 0; i < 42; i++) begin
            cyc();
        end
        chk("t3_no_early_wb", n_wb, 32'd0);
        set_md(1'b1, 1'b0, 32'h1234_5678);
        cyc();
        chk("t3_wb_valid", s_wb, 32'd1);
        chk("t3_wb_rd", s_rd, 32'd30);
        chk("t3_wb_data", s_data, 32'd7);
        chk("t3_done_stall", s_stall, 32'd0);
        set_x(1'b0, 5'd0, 5'd0, 5'd0);
        cyc();
        chk("t3_late_ready_busy", s_busy, 32'd0);
        cyc();
        chk("t3_late_ready_wb", s_wb, 32'd0);
        set_md(1'b0, 1'b0, 32'd0);
        chk("t3_stall_cycles", n_stall, 32'd42);
        chk("t3_mult_pulses", n_smul, 32'd1);
        chk("t3_wb_count", n_wb, 32'd1);

        // Test 4: back-to-back muls rd=3 then rd=4
        clr_counts();
        set_x(1'b1, 5'b00000, 5'b00110, 5'd3);
        cyc();
        cyc();
        set_md(1'b1, 1'b0, 32'h0000_0011);
        cyc();
        set_md(1'b0, 1'b0, 32'd0);
        cyc();
        chk("t4_first_wb_rd", s_rd, 32'd3);
        chk("t4_first_wb_data", s_data, 32'h0000_0011);
        set_x(1'b1, 5'b00000, 5'b00110, 5'd4);
        cyc();
        chk("t4_second_detect_stall", s_stall, 32'd1);
        chk("t4_second_detect_busy", s_busy, 32'd0);
        cyc();
        chk("t4_second_start", s_smul, 32'd1);
        set_md(1'b1, 1'b0, 32'h0000_0022);
        cyc();
        set_md(1'b0, 1'b0, 32'd0);
        cyc();
        chk("t4_second_wb_rd", s_rd, 32'd4);
        chk("t4_second_wb_data", s_data, 32'h0000_0022);
        set_x(1'b0, 5'd0, 5'd0, 5'd0);
        cyc();
        chk("t4_mult_pulses", n_smul, 32'd2);
        chk("t4_wb_count", n_wb, 32'd2);
        chk("t4_stall_cycles", n_stall, 32'd6);

        // Test 5: reset mid-WAIT, then stale ready while idle
        clr_counts();
        set_x(1'b1, 5'b00000, 5'b00110, 5'd5);
        cyc();
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        set_x(1'b0, 5'd0, 5'd0, 5'd0);
        set_md(1'b1, 1'b0, 32'h0000_0099);
        cyc();
        chk("t5_busy_after_rst", s_busy, 32'd0);
        chk("t5_stall_after_rst", s_stall, 32'd0);
        chk("t5_wb_after_rst", s_wb, 32'd0);
        cyc();
        chk("t5_stale_ready_busy", s_busy, 32'd0);
        set_md(1'b0, 1'b0, 32'd0);
        cyc();
        chk("t5_wb_count", n_wb, 32'd0);
        chk("t5_mult_pulses", n_smul, 32'd1);

        // Test 6: non-mul/div instructions and bubbles cause no action
        clr_counts();
        set_x(1'b1, 5'b00001, 5'b00110, 5'd1);
        cyc();
        chk("t6_op00001_stall", s_stall, 32'd0);
        set_x(1'b1, 5'b00011, 5'b00110, 5'd1);
        cyc();
        chk("t6_op00011_stall", s_stall, 32'd0);
        set_x(1'b1, 5'b10110, 5'b00110, 5'd1);
        cyc();
        chk("t6_op10110_stall", s_stall, 32'd0);
        set_x(1'b1, 5'b10101, 5'b00111, 5'd1);
        cyc();
        chk("t6_op10101_stall", s_stall, 32'd0);
        set_x(1'b1, 5'b00000, 5'b00000, 5'd1);
        cyc();
        chk("t6_aluop0_stall", s_stall, 32'd0);
        set_x(1'b0, 5'b00000, 5'b00110, 5'd1);
        cyc();
        chk("t6_bubble_stall", s_stall, 32'd0);
        set_x(1'b0, 5'd0, 5'd0, 5'd0);
        cyc();
        chk("t6_busy", s_busy, 32'd0);
        chk("t6_start_pulses", n_smul + n_sdiv, 32'd0);
        chk("t6_stall_cycles", n_stall, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
